// File: rtl/cosh_series_unit_pkg.sv
// Shared types and fixed-point widths for the cosh series evaluator.
package cosh_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, STEP_A, STEP_B, DONE} cosh_state_t;

  localparam int FRAC_W = 8;
  localparam int TERM_W = 9;
  localparam int SUM_W  = 10;
  localparam logic [TERM_W-1:0] ONE_TERM = 9'h100;
  localparam logic [SUM_W-1:0]  ONE_SUM  = 10'h100;
endpackage

// File: rtl/cosh_series_unit_if.sv
// Start/busy/done handshake plus operand and result between the controlling FSM and the unit.
interface cosh_series_unit_if;
  logic       start;
  logic [7:0] x;
  logic       busy;
  logic       done;
  logic [9:0] result;

  modport master (output start, x, input busy, done, result);
  modport slave  (input start, x, output busy, done, result);
endinterface

// File: rtl/cosh_series_unit_ctrl.sv
// Sequencer for the cosh series: FSM, term index k, handshake flags and datapath enables.
module cosh_series_ctrl
  import cosh_pkg::*;
#(
  parameter int N_TERMS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] lut_adr,
  output logic       accept,
  output logic       init,
  output logic       step_a,
  output logic       step_b,
  output logic       last
);
  localparam logic [2:0] K_LAST = 3'(N_TERMS - 1);

  cosh_state_t state;
  logic [2:0]  k;

  assign accept  = (state == IDLE) && start;
  assign init    = (state == LOAD);
  assign step_a  = (state == STEP_A);
  assign step_b  = (state == STEP_B);
  assign last    = step_b && (k == K_LAST);
  // k only moves in LOAD and STEP_B, so the LUT output is settled by STEP_B
  assign lut_adr = k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: begin
          k     <= '0;
          state <= STEP_A;
        end
        STEP_A: state <= STEP_B;
        STEP_B: if (k == K_LAST) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          k     <= k + 3'd1;
          state <= STEP_A;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/cosh_series_unit.sv
// Iterative cosh(x) evaluator: x in 0.8, result in 2.8, coefficients fetched from an external LUT.
module cosh_series_unit
  import cosh_pkg::*;
#(
  parameter int N_TERMS = 8
) (
  input  logic                clk,
  input  logic                rst,
  cosh_series_unit_if.slave   bus,
  output logic [2:0]          lut_adr,
  input  logic [FRAC_W-1:0]   lut_data
);
  logic              accept, init, step_a, step_b, last;
  logic [FRAC_W-1:0] x_r, x2;
  logic [TERM_W-1:0] term, t_b;
  logic [SUM_W-1:0]  sum, sum_next;
  logic [15:0]       sq;
  logic [16:0]       prod_a, prod_b;

  cosh_series_ctrl #(.N_TERMS(N_TERMS)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.start),
    .busy    (bus.busy),
    .done    (bus.done),
    .lut_adr (lut_adr),
    .accept  (accept),
    .init    (init),
    .step_a  (step_a),
    .step_b  (step_b),
    .last    (last)
  );

  // Full-width products, floored back to 0.8 by dropping the low byte
  assign sq       = x_r * x_r;
  assign prod_a   = term * x2;
  assign prod_b   = term * lut_data;
  assign t_b      = prod_b[16:8];
  assign sum_next = sum + SUM_W'(t_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r        <= '0;
      x2         <= '0;
      term       <= '0;
      sum        <= '0;
      bus.result <= '0;
    end else begin
      if (accept) x_r <= bus.x;
      if (init) begin
        x2   <= sq[15:8];
        term <= ONE_TERM;
        sum  <= ONE_SUM;
      end
      if (step_a) term <= prod_a[16:8];
      if (step_b) begin
        term <= t_b;
        sum  <= sum_next;
        if (last) bus.result <= sum_next;
      end
    end
  end
endmodule

// File: tb/tb_cosh_series_unit.sv
// Bench for cosh_series_unit: N_TERMS=8 and N_TERMS=1 instances, each fed by a coefficient LUT.
module tb_cosh_series_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cosh_series_unit_if bus8 ();
  cosh_series_unit_if bus1 ();
  logic [2:0] lut_adr8, lut_adr1;
  logic [7:0] lut_data8, lut_data1;

  function automatic int coef(input int k);
    return 256 / ((2 * k + 1) * (2 * k + 2));
  endfunction

  // Series evaluated straight from the definition with floor division
  function automatic int cosh_ref(input int xv, input int n);
    int x2, term, sum;
    x2 = (xv * xv) / 256;
    term = 256;
    sum = 256;
    for (int k = 0; k < n; k++) begin
      term = (term * x2) / 256;
      term = (term * coef(k)) / 256;
      sum  = (sum + term) % 1024;
    end
    return sum;
  endfunction

  always_comb begin
    lut_data8 = 8'(coef(int'(lut_adr8)));
    lut_data1 = 8'(coef(int'(lut_adr1)));
  end

  cosh_series_unit #(.N_TERMS(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave), .lut_adr(lut_adr8), .lut_data(lut_data8));
  cosh_series_unit #(.N_TERMS(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .lut_adr(lut_adr1), .lut_data(lut_data1));

  bit         sel = 1'b0;
  logic       m_busy, m_done;
  logic [2:0] m_adr;
  logic [9:0] m_res;
  assign m_busy = sel ? bus1.busy   : bus8.busy;
  assign m_done = sel ? bus1.done   : bus8.done;
  assign m_adr  = sel ? lut_adr1    : lut_adr8;
  assign m_res  = sel ? bus1.result : bus8.result;

  task automatic set_in(input bit s, input logic st, input logic [7:0] xv);
    if (s) begin bus1.start = st; bus1.x = xv; end
    else   begin bus8.start = st; bus8.x = xv; end
  endtask

  // One operation; returns result, done edge index and counts of busy/lut_adr deviations
  task automatic run_op(input bit s, input logic [7:0] xv, input int n,
                        output logic [9:0] res, output int lat,
                        output int berr, output int aerr);
    int exp_k;
    sel = s;
    set_in(s, 1'b1, xv);
    @(posedge clk); #1;
    set_in(s, 1'b0, 8'($urandom));
    lat = -1; berr = 0; aerr = 0;
    if (m_busy !== 1'b1) berr++;
    for (int e = 1; e <= 60 && lat < 0; e++) begin
      @(posedge clk); #1;
      exp_k = (e - 1) / 2;
      if (exp_k > n - 1) exp_k = n - 1;
      if (m_busy !== 1'b1) berr++;
      if (m_adr !== 3'(exp_k)) aerr++;
      if (m_done === 1'b1) lat = e;
    end
    res = m_res;
    @(posedge clk); #1;
    if (m_done !== 1'b0 || m_busy !== 1'b0) berr++;
    if (m_res !== res) berr++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    if ({bus8.busy, bus8.done} !== 2'b00) begin
      bad++; $display("FAIL reset_flags8 got=%b exp=00", {bus8.busy, bus8.done});
    end
    total++;
    if (bus8.result !== 10'h000 || lut_adr8 !== 3'd0) begin
      bad++; $display("FAIL reset_data8 result=%h adr=%0d exp=000/0", bus8.result, lut_adr8);
    end
    total++;
    if ({bus1.busy, bus1.done} !== 2'b00 || bus1.result !== 10'h000) begin
      bad++; $display("FAIL reset_dut1 busy/done=%b result=%h exp=00/000",
                      {bus1.busy, bus1.done}, bus1.result);
    end
    total++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [7:0] xs [3] = '{8'h00, 8'h80, 8'hFF};
    logic [9:0] es [3] = '{10'h100, 10'h120, 10'h189};
    logic [9:0] res;
    int lat, berr, aerr;
    for (int i = 0; i < 3; i++) begin
      run_op(0, xs[i], 8, res, lat, berr, aerr);
      if (res !== es[i]) begin
        bad++; $display("FAIL vec_result x=%h got=%h exp=%h", xs[i], res, es[i]);
      end
      total++;
      if (lat !== 17) begin
        bad++; $display("FAIL vec_latency x=%h got=%0d exp=17", xs[i], lat);
      end
      total++;
      if (berr !== 0 || aerr !== 0) begin
        bad++; $display("FAIL vec_busy_adr x=%h busy_err=%0d adr_err=%0d exp=0/0", xs[i], berr, aerr);
      end
      total++;
    end
  endtask

  task automatic test_random();
    logic [7:0] xv;
    logic [9:0] res;
    int lat, berr, aerr;
    for (int i = 0; i < 16; i++) begin
      xv = 8'($urandom);
      run_op(0, xv, 8, res, lat, berr, aerr);
      if (res !== 10'(cosh_ref(int'(xv), 8)) || lat !== 17 || berr !== 0 || aerr !== 0) begin
        bad++;
        $display("FAIL rand_op x=%h got=%h/lat%0d/b%0d/a%0d exp=%h/lat17/b0/a0",
                 xv, res, lat, berr, aerr, 10'(cosh_ref(int'(xv), 8)));
      end
      total++;
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    sel = 0;
    set_in(0, 1'b1, 8'hFF);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'hFF);
    for (int e = 1; e <= 60 && lat < 0; e++) begin
      @(posedge clk); #1;
      if (e == 2) bus8.x = 8'h00;
      if (e == 4) set_in(0, 1'b1, 8'h5A);
      if (e == 5) set_in(0, 1'b0, 8'h11);
      if (bus8.done === 1'b1) lat = e;
    end
    if (bus8.result !== 10'h189 || lat !== 17) begin
      bad++; $display("FAIL ignore_result got=%h lat=%0d exp=189 lat=17", bus8.result, lat);
    end
    total++;
    // start seen only while in DONE must not launch another run
    set_in(0, 1'b1, 8'h33);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'h33);
    if (bus8.busy !== 1'b0) begin
      bad++; $display("FAIL ignore_done_start busy=%b exp=0", bus8.busy);
    end
    total++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] xa, xb;
    logic [9:0] ra, rb;
    int d1 = -1, d2 = -1;
    xa = 8'($urandom); xb = 8'($urandom);
    sel = 0;
    set_in(0, 1'b1, xa);
    @(posedge clk); #1;
    for (int e = 1; e <= 80 && d2 < 0; e++) begin
      @(posedge clk); #1;
      if (bus8.done === 1'b1) begin
        if (d1 < 0) begin d1 = e; ra = bus8.result; bus8.x = xb; end
        else begin d2 = e; rb = bus8.result; end
      end
    end
    set_in(0, 1'b0, 8'h00);
    // DONE at +1, IDLE accepts at +2, then a full 17-edge run
    if (d1 !== 17 || d2 !== 36) begin
      bad++; $display("FAIL b2b_latency got=%0d/%0d exp=17/36", d1, d2);
    end
    total++;
    if (ra !== 10'(cosh_ref(int'(xa), 8)) || rb !== 10'(cosh_ref(int'(xb), 8))) begin
      bad++; $display("FAIL b2b_result got=%h/%h exp=%h/%h", ra, rb,
                      10'(cosh_ref(int'(xa), 8)), 10'(cosh_ref(int'(xb), 8)));
    end
    total++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    logic [7:0] xv;
    logic [9:0] res;
    int lat, berr, aerr;
    sel = 0;
    set_in(0, 1'b1, 8'hFF);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'hFF);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    if ({bus8.busy, bus8.done} !== 2'b00 || bus8.result !== 10'h000 || lut_adr8 !== 3'd0) begin
      bad++; $display("FAIL mid_reset busy/done=%b result=%h adr=%0d exp=00/000/0",
                      {bus8.busy, bus8.done}, bus8.result, lut_adr8);
    end
    total++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xv = 8'($urandom);
    run_op(0, xv, 8, res, lat, berr, aerr);
    if (res !== 10'(cosh_ref(int'(xv), 8)) || lat !== 17) begin
      bad++; $display("FAIL post_reset_op x=%h got=%h lat=%0d exp=%h lat=17",
                      xv, res, lat, 10'(cosh_ref(int'(xv), 8)));
    end
    total++;
  endtask

  task automatic test_single_term();
    logic [7:0] xv;
    logic [9:0] res;
    int lat, berr, aerr;
    run_op(1, 8'h80, 1, res, lat, berr, aerr);
    if (res !== 10'h120 || lat !== 3 || berr !== 0 || aerr !== 0) begin
      bad++; $display("FAIL n1_vector got=%h lat=%0d b%0d a%0d exp=120 lat=3 b0 a0",
                      res, lat, berr, aerr);
    end
    total++;
    for (int i = 0; i < 4; i++) begin
      xv = 8'($urandom);
      run_op(1, xv, 1, res, lat, berr, aerr);
      if (res !== 10'(cosh_ref(int'(xv), 1)) || lat !== 3) begin
        bad++; $display("FAIL n1_rand x=%h got=%h lat=%0d exp=%h lat=3",
                        xv, res, lat, 10'(cosh_ref(int'(xv), 1)));
      end
      total++;
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_single_term();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
